mux_n_way_stream: RTL and testbench

//  Parametrised WAYS-to-1, WIDTH-bit multiplexer with a registered output and valid/ready handshakes.
//  Two modes: mode=0 passes the channel named by select; mode=1 arbitrates round-robin among valid channels.
//  One output register stage: one cycle of latency and full throughput.

---
 rtl/mux_n_way_stream.sv | 122 ++++++++++++
 tb/tb_mux_n_way_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_way_stream.sv
// -----------------------------------------------------------------------------
// mux_n_way_stream
//   WAYS-to-1, WIDTH-bit stream multiplexer with one registered output stage
//   and valid/ready handshakes on every channel.  mode=0 passes the channel
//   named by select; mode=1 arbitrates round-robin among the valid channels.
//   One cycle of latency and one word per cycle of sustained throughput.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   in_data      in   WAYS*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid     in   per-channel valid
//   in_ready     out  per-channel ready, one-hot or zero
//   select       in   channel choice used when mode=0
//   mode         in   0 = select-driven, 1 = round-robin
//   out_data     out  registered data
//   out_valid    out  out_data holds a word not yet taken
//   out_ready    in   consumer accepts out_data
//   out_channel  out  index of the channel that produced out_data
// -----------------------------------------------------------------------------
module mux_n_way_stream #(
    parameter  int WIDTH = 16,
    parameter  int WAYS  = 4,
    localparam int SEL_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
    input  logic [SEL_W-1:0]      select,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_channel
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_channel_q, out_channel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             can_load;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    // Grant selection.  In round-robin mode the search starts at rr_ptr and
    // wraps modulo WAYS, so non-power-of-2 channel counts wrap correctly.
    always_comb begin : grant_logic
        int idx;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned -- that is what keeps always_comb latch-free.
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (!mode) begin
            // An out-of-range select (possible when WAYS is not a power of 2)
            // simply produces no grant.
            if (int'(select) < WAYS) begin
                grant       = select;
                grant_valid = in_valid[select];
            end
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                idx = (int'(rr_ptr_q) + k) % WAYS;
                if (!grant_valid && in_valid[idx]) begin
                    grant       = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // The register can take a new word when empty or when its word leaves
    // this cycle; this gives full throughput at the cost of a combinational
    // path from out_ready to in_ready.
    assign can_load = !out_valid_q || out_ready;
    assign transfer = rst_n && can_load && grant_valid;
    assign in_ready = transfer ? (WAYS'(1) << grant) : '0;
    assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];

    always_comb begin : next_state
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        rr_ptr_d      = rr_ptr_q;
        if (transfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = sel_data;
            out_channel_d = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (transfer && mode) begin
            rr_ptr_d = (int'(grant) == WAYS - 1) ? '0 : grant + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_mux_n_way_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_n_way_stream
//   Self-checking bench for mux_n_way_stream.  A 4-way instance is driven
//   scenario by scenario against a reference grant model and a scoreboard of
//   expected output words; a 3-way instance covers the out-of-range select.
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_mux_n_way_stream;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   ch;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [1:0]     select;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_channel;

    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [1:0]     select3;
    logic           mode3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_ready3;
    logic [1:0]     out_channel3;

    always #5 clk = ~clk;

    mux_n_way_stream #(.WIDTH(W), .WAYS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .select(select), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel)
    );

    mux_n_way_stream #(.WIDTH(W), .WAYS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .select(select3), .mode(mode3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_channel(out_channel3)
    );

    word_t      sb[$];
    logic [1:0] m_rr;
    int         errors = 0;
    int         checks = 0;

    // Reference arbiter for the 4-way instance.
    function automatic void model_grant(output logic v, output logic [1:0] g);
        v = 1'b0;
        g = 2'd0;
        if (!mode) begin
            g = select;
            v = in_valid[select];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (int'(m_rr) + k) % N;
                if (!v && in_valid[idx]) begin
                    v = 1'b1;
                    g = idx[1:0];
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic       v;
        logic [1:0] g;
        logic       can_load;
        model_grant(v, g);
        can_load = (sb.size() == 0) || out_ready;
        return (rst_n && can_load && v) ? (4'b0001 << g) : 4'b0000;
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic advance();
        logic         v;
        logic [1:0]   g;
        logic [N-1:0] rdy;
        word_t        w;
        model_grant(v, g);
        rdy = model_ready();
        @(posedge clk);
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (rdy != '0) begin
            w.data = in_data[int'(g)*W +: W];
            w.ch   = g;
            sb.push_back(w);
            if (mode) m_rr = g + 2'd1;
        end
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mode      = 1'b0;
        select    = 2'd0;
        set_data(16'h5500);
        in_data3  = '0; in_valid3 = '0; select3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
        sb.delete();
        m_rr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_channel !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h ch=%0d, required 0/0000/0", out_valid, out_data, out_channel);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0000;
    endtask

    task automatic test_select();
        @(negedge clk);
        mode = 1'b0; select = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = '0;
        in_data[2*W +: W] = 16'hCAFE;
        #1;
        checks++;
        if (in_ready !== 4'b0100 || in_ready !== model_ready()) begin
            errors++;
            $display("FAIL select_in_ready: got %b, required 0100", in_ready);
        end
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hCAFE || out_channel !== 2'd2) begin
            errors++;
            $display("FAIL select_out: valid=%b data=%h ch=%0d, required 1/cafe/2", out_valid, out_data, out_channel);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        advance();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL select_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        mode = 1'b0; select = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(16'hB0B0);
        advance();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            select    = 2'(c);
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %b, required 0000", c, in_ready);
            end
            advance();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hB0B1 || out_channel !== 2'd1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h ch=%0d, required 1/b0b1/1", c, out_valid, out_data, out_channel);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        select    = 2'd3;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL stall_release_ready: got %b, required 1000", in_ready);
        end
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hB0B3 || out_channel !== 2'd3) begin
            errors++;
            $display("FAIL stall_release_out: valid=%b data=%h ch=%0d, required 1/b0b3/3", out_valid, out_data, out_channel);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(16'h0A00);
        for (int k = 0; k < 5; k++) begin
            advance();
            checks++;
            if (out_valid !== 1'b1 || out_channel !== 2'(k % N) || out_data !== 16'h0A00 + W'(k % N)) begin
                errors++;
                $display("FAIL rr_seq[%0d]: valid=%b ch=%0d data=%h, required 1/%0d/%h", k, out_valid, out_channel, out_data, k % N, 16'h0A00 + W'(k % N));
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [1:0] exp_ch [2];
        exp_ch[0] = 2'd3;
        exp_ch[1] = 2'd0;
        @(negedge clk);
        in_valid = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            advance();
            checks++;
            if (out_valid !== 1'b1 || out_channel !== exp_ch[k] || out_data !== 16'h0A00 + W'(exp_ch[k])) begin
                errors++;
                $display("FAIL rr_skip[%0d]: ch=%0d data=%h, required %0d", k, out_channel, out_data, exp_ch[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: out_valid=%b, required 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        sb.delete();
        m_rr = 2'd0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_channel !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_async: valid=%b data=%h ch=%0d rdy=%b, required 0/0000/0/0000", out_valid, out_data, out_channel, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b, required 0001", in_ready);
        end
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_channel !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_first: valid=%b ch=%0d, required 1/0", out_valid, out_channel);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid  = 4'($urandom_range(0, 15));
            mode      = 1'($urandom_range(0, 1));
            select    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b, required %b", c, in_ready, model_ready());
            end
            advance();
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %b, required %b", c, out_valid, sb.size() != 0);
            end else if (sb.size() != 0) begin
                checks++;
                if (out_data !== sb[0].data || out_channel !== sb[0].ch) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: data=%h ch=%0d, required %h/%0d", c, out_data, out_channel, sb[0].data, sb[0].ch);
                end
            end
        end
    endtask

    task automatic test_ways3();
        @(negedge clk);
        mode3 = 1'b0; select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {16'h3333, 16'h2222, 16'h1111};
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            errors++;
            $display("FAIL w3_oob_ready: got %b, required 000", in_ready3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL w3_oob_valid: got %b, required 0", out_valid3);
        end
        @(negedge clk);
        select3 = 2'd1;
        #1;
        checks++;
        if (in_ready3 !== 3'b010) begin
            errors++;
            $display("FAIL w3_sel1_ready: got %b, required 010", in_ready3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 16'h2222 || out_channel3 !== 2'd1) begin
            errors++;
            $display("FAIL w3_sel1_out: valid=%b data=%h ch=%0d, required 1/2222/1", out_valid3, out_data3, out_channel3);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_backpressure();
        test_round_robin();
        test_skip_wrap();
        test_reset_mid();
        test_back_to_back();
        test_ways3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
